// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for the 4-digit common-anode
// seven-segment display. It double-buffers a 4-digit BCD value and scans one
// digit per slot: a BLANK phase (all anodes off) followed by a SHOW phase.
// New values are only promoted to the displayed buffer at the frame wrap, so a
// frame never mixes digits from two different values.
// Optional feature: define LZ_SUPPRESS_EN to blank leading zeros (digit 0 is
// always kept so a zero value still shows a single "0").
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_val_q, act_val_d;
  logic [3:0]       act_en_q, act_en_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [3:0]       pend_en_q, pend_en_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q, frame_done_d;

  logic             blank_done;
  logic             show_done;
  logic             wrap;
  logic [3:0]       cur_nib;
  logic [3:0]       show_en;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD nibbles render as a blank digit
  function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  assign cur_nib = act_val_q[{idx_q, 2'b00} +: 4];

  // State register plus all datapath flops; reset drops every pin to dark at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_val_q    <= 16'h0000;
      act_en_q     <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_en_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: phase counter, BLANK/SHOW alternation and digit index advance
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    blank_done = 1'b0;
    show_done  = 1'b0;
    wrap       = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          blank_done = 1'b1;
          state_d    = ST_SHOW;
          cnt_d      = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          show_done = 1'b1;
          state_d   = ST_BLANK;
          cnt_d     = '0;
          idx_d     = idx_q + 2'd1;
          wrap      = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Effective anode enables for the displayed buffer (optionally hiding leading zeros)
  always_comb begin
    show_en = act_en_q;
`ifdef LZ_SUPPRESS_EN
    if (act_val_q[15:12] == 4'h0) begin
      show_en[3] = 1'b0;
      if (act_val_q[11:8] == 4'h0) begin
        show_en[2] = 1'b0;
        if (act_val_q[7:4] == 4'h0) begin
          show_en[1] = 1'b0;
        end
      end
    end
`endif
  end

  // Double buffer: loads park in pending; the frame wrap promotes them, a load on the wrap wins
  always_comb begin
    act_val_d    = act_val_q;
    act_en_d     = act_en_q;
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    if (wrap) begin
      if (load) begin
        act_val_d = value;
        act_en_d  = digit_en;
      end else if (pend_valid_q) begin
        act_val_d = pend_val_q;
        act_en_d  = pend_en_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end
  end

  // Output decode: registered pins change only when a phase begins
  always_comb begin
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    frame_done_d = wrap;
    if (state_q == ST_BLANK && blank_done) begin
      seg_d = decode_bcd(cur_nib);
      if (show_en[idx_q]) begin
        an_d = ~(4'b0001 << idx_q);
      end
    end else if (state_q == ST_SHOW && !show_done) begin
      an_d  = an_q;
      seg_d = seg_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed frame-by-frame checks of seg_scan_ctrl with a
// 40-cycle frame (REFRESH_DIV=8, BLANK_CYC=2). Expected segment patterns are
// hand-written per frame; LZ_SUPPRESS_EN switches the expected anode masks.
module tb_seg_scan_ctrl;

  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 2;
  localparam int SLOT        = REFRESH_DIV + BLANK_CYC;
  localparam int FRAME       = 4 * SLOT;

`ifdef LZ_SUPPRESS_EN
  localparam logic [3:0] EN_00A9 = 4'b0001;
  localparam logic [3:0] EN_0070 = 4'b0011;
  localparam logic [3:0] EN_0000 = 4'b0001;
`else
  localparam logic [3:0] EN_00A9 = 4'b0101;
  localparam logic [3:0] EN_0070 = 4'b1111;
  localparam logic [3:0] EN_0000 = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int          n_compared   = 0;
  int          n_mismatched = 0;

  int          ld_cyc [3];
  logic [15:0] ld_val [3];
  logic [3:0]  ld_en  [3];

  seg_scan_ctrl #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .digit_en  (digit_en),
    .load      (load),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drive the input bus for the next rising edge
  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] en);
    load     = ld;
    value    = v;
    digit_en = en;
  endtask

  // Forget any loads scheduled for the previous frame
  task automatic clearLoads();
    for (int k = 0; k < 3; k++) begin
      ld_cyc[k] = -1;
      ld_val[k] = 16'h0000;
      ld_en[k]  = 4'h0;
    end
  endtask

  // Queue a one-cycle load at frame cycle c of the next runFrame
  task automatic scheduleLoad(input int k, input int c, input logic [15:0] v, input logic [3:0] en);
    ld_cyc[k] = c;
    ld_val[k] = v;
    ld_en[k]  = en;
  endtask

  // Walk n_cyc cycles of one frame, starting at the negedge of frame cycle 0
  task automatic runFrame(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_en,
                          input logic exp_fd, input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      int         s;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fd;
      logic       hit;
      s = c / SLOT;
      if ((c % SLOT) < BLANK_CYC) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end else begin
        e_seg = exp_seg[s*7 +: 7];
        e_an  = exp_en[s] ? ~(4'b0001 << s) : 4'hF;
      end
      e_fd = (c == 0) ? exp_fd : 1'b0;
      checkOutput($sformatf("%s c%0d an", tag, c), {12'h000, an}, {12'h000, e_an});
      checkOutput($sformatf("%s c%0d seg", tag, c), {9'h000, seg}, {9'h000, e_seg});
      checkOutput($sformatf("%s c%0d frame_done", tag, c), {15'h0000, frame_done}, {15'h0000, e_fd});
      hit = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (ld_cyc[k] == c) begin
          applyStimulus(1'b1, ld_val[k], ld_en[k]);
          hit = 1'b1;
        end
      end
      if (!hit) begin
        applyStimulus(1'b0, value, digit_en);
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, value, digit_en);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0);
    clearLoads();
    repeat (3) @(negedge clk);
    checkOutput("reset an", {12'h000, an}, 16'h000F);
    checkOutput("reset seg", {9'h000, seg}, 16'h007F);
    checkOutput("reset frame_done", {15'h0000, frame_done}, 16'h0000);
    rst_n = 1'b1;

    $display("[TB] frame 1: zero value, pending load of 1234");
    scheduleLoad(0, 5, 16'h1234, 4'hF);
    runFrame("f1", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0, 1'b0, FRAME);

    $display("[TB] frame 2: 1234, mid-frame load of 5678");
    clearLoads();
    scheduleLoad(0, 12, 16'h5678, 4'hF);
    runFrame("f2", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, FRAME);

    $display("[TB] frame 3: 5678, loads 1111/2222 then 3333 on the wrap");
    clearLoads();
    scheduleLoad(0, 3, 16'h1111, 4'hF);
    scheduleLoad(1, 20, 16'h2222, 4'hF);
    scheduleLoad(2, FRAME - 1, 16'h3333, 4'hF);
    runFrame("f3", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 1'b1, FRAME);

    $display("[TB] frame 4: 3333, load 00A9 with digit_en 0101");
    clearLoads();
    scheduleLoad(0, 7, 16'h00A9, 4'b0101);
    runFrame("f4", {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 1'b1, FRAME);

    $display("[TB] frame 5: 00A9 partially enabled, load 5678");
    clearLoads();
    scheduleLoad(0, 25, 16'h5678, 4'hF);
    runFrame("f5", {7'h40, 7'h40, 7'h7F, 7'h10}, EN_00A9, 1'b1, FRAME);

    $display("[TB] frame 6: 5678 interrupted by reset in digit 2 SHOW");
    clearLoads();
    runFrame("f6", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 1'b1, 2 * SLOT + 4);
    checkOutput("pre-reset an", {12'h000, an}, 16'h000B);
    checkOutput("pre-reset seg", {9'h000, seg}, 16'h0002);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset an", {12'h000, an}, 16'h000F);
    checkOutput("async reset seg", {9'h000, seg}, 16'h007F);
    checkOutput("async reset frame_done", {15'h0000, frame_done}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] frame 7: restart after reset, active value cleared, load 0070");
    scheduleLoad(0, 30, 16'h0070, 4'hF);
    runFrame("f7", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0, 1'b0, FRAME);

    $display("[TB] frame 8: 0070, load 0000");
    clearLoads();
    scheduleLoad(0, 15, 16'h0000, 4'hF);
    runFrame("f8", {7'h40, 7'h40, 7'h78, 7'h40}, EN_0070, 1'b1, FRAME);

    $display("[TB] frame 9: 0000");
    clearLoads();
    runFrame("f9", {7'h40, 7'h40, 7'h40, 7'h40}, EN_0000, 1'b1, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
